// File: rtl/vmx_pkg.sv
// Shared definitions for the VMX stream sequencer: FSM state encodings,
// lane-width constants and the clog2 helper used for port sizing.
package vmx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GETW   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } vmx_state_e;

  // Default input lane width; product lanes are VMX_LANE_MULT times wider.
  localparam int unsigned VMX_PORT_WIDTH = 16;
  localparam int unsigned VMX_LANE_MULT  = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned vmx_clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vmx_skew_line.sv
// Triangular delay line. Lane k is delayed k cycles (REVERSE=0) or
// LANES-1-k cycles (REVERSE=1); zero-delay lanes are combinational.
module vmx_skew_line #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter bit          REVERSE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] din,
  output logic [LANES*WIDTH-1:0] dout
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int unsigned DLY = REVERSE ? (LANES - 1 - k) : k;

    if (DLY == 0) begin : g_pass
      assign dout[k*WIDTH +: WIDTH] = din[k*WIDTH +: WIDTH];
    end else begin : g_dly
      logic [WIDTH-1:0] sr [0:DLY-1];

      // Shift this lane through DLY register stages
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < DLY; i++) sr[i] <= '0;
        end else begin
          sr[0] <= din[k*WIDTH +: WIDTH];
          for (int unsigned i = 1; i < DLY; i++) sr[i] <= sr[i-1];
        end
      end

      assign dout[k*WIDTH +: WIDTH] = sr[DLY-1];
    end
  end

endmodule

// File: rtl/vmx_stream_sequencer.sv
// VMX systolic-array stream sequencer: loads a weight tile, streams input
// vectors through an input skew, de-skews products and writes them back.
// Optional macro VMX_PERF_EN adds the perf_cycles busy-cycle counter port.
module vmx_stream_sequencer
  import vmx_pkg::*;
#(
  parameter int unsigned PE_SIZE    = 4,
  parameter int unsigned PORT_WIDTH = VMX_PORT_WIDTH,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned PE_LAT     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [ADDR_W-1:0]                    rbase_addr,
  input  logic [ADDR_W-1:0]                    wbase_addr,
  input  logic [ADDR_W-1:0]                    num_vec,
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           state,
  output logic [ADDR_W-1:0]                    mem_raddr,
  output logic                                 mem_rd_en,
  input  logic [PE_SIZE*PORT_WIDTH-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]                    mem_waddr,
  output logic                                 mem_wr_en,
  output logic [2*PE_SIZE*PORT_WIDTH-1:0]      mem_wdata,
  output logic                                 pe_clr,
  output logic                                 pe_w_valid,
  output logic [vmx_clog2(PE_SIZE)-1:0]        pe_w_row,
  output logic [PE_SIZE*PORT_WIDTH-1:0]        pe_weight,
  output logic [PE_SIZE*PORT_WIDTH-1:0]        pe_vector,
  input  logic [2*PE_SIZE*PORT_WIDTH-1:0]      pe_product
`ifdef VMX_PERF_EN
  ,
  output logic [31:0]                          perf_cycles
`endif
);

  localparam int unsigned ROW_W       = vmx_clog2(PE_SIZE);
  localparam int unsigned LANE_W      = PE_SIZE * PORT_WIDTH;
  localparam int unsigned PROD_LANE_W = VMX_LANE_MULT * PORT_WIDTH;
  localparam int unsigned PROD_W      = PE_SIZE * PROD_LANE_W;
  // Cycles from a vector's lane-0 entry to its fully aligned result.
  localparam int unsigned WB_LAT      = PE_LAT + PE_SIZE - 1;

  vmx_state_e        state_q;
  logic [ADDR_W-1:0] rbase_q, wbase_q, nvec_q, rd_cnt, wr_cnt;
  logic              rd_tag;
  logic [RD_LAT-1:0] rd_vld_q, rd_vec_q;
  logic [WB_LAT-1:0] wb_vld_q;
  logic [ROW_W-1:0]  w_row_q;
  logic              ret_vld, ret_vec, ret_wgt, start_ok;
  logic [LANE_W-1:0] vec_in;
  logic [PROD_W-1:0] prod_aligned;

  assign start_ok = (state_q == S_IDLE) && start && !abort;
  assign ret_vld  = rd_vld_q[RD_LAT-1];
  assign ret_vec  = ret_vld &  rd_vec_q[RD_LAT-1];
  assign ret_wgt  = ret_vld & ~rd_vec_q[RD_LAT-1];

  // Job FSM: read issue, address generation and registered control pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rbase_q   <= '0;
      wbase_q   <= '0;
      nvec_q    <= '0;
      rd_cnt    <= '0;
      rd_tag    <= 1'b0;
      mem_raddr <= '0;
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      pe_clr    <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      rd_tag    <= 1'b0;
      done      <= 1'b0;
      pe_clr    <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_GETW;
              rbase_q <= rbase_addr;
              wbase_q <= wbase_addr;
              nvec_q  <= num_vec;
              rd_cnt  <= '0;
              pe_clr  <= 1'b1;
            end
          end
          S_GETW: begin
            mem_rd_en <= 1'b1;
            mem_raddr <= rbase_q + rd_cnt;
            if (rd_cnt == ADDR_W'(PE_SIZE - 1)) begin
              rd_cnt  <= '0;
              state_q <= (nvec_q != '0) ? S_STREAM : S_DRAIN;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
          S_STREAM: begin
            mem_rd_en <= 1'b1;
            rd_tag    <= 1'b1;
            mem_raddr <= rbase_q + ADDR_W'(PE_SIZE) + rd_cnt;
            rd_cnt    <= rd_cnt + 1'b1;
            if (rd_cnt == nvec_q - 1'b1) state_q <= S_DRAIN;
          end
          S_DRAIN: begin
            // The write in flight this cycle counts, so done lands one cycle after it.
            if ((wr_cnt + ADDR_W'(mem_wr_en)) == nvec_q && rd_vld_q == '0 && !mem_rd_en) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Read-return tracking, write-back valid pipeline and write/row counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= '0;
      rd_vec_q <= '0;
      wb_vld_q <= '0;
      wr_cnt   <= '0;
      w_row_q  <= '0;
    end else if (abort) begin
      rd_vld_q <= '0;
      rd_vec_q <= '0;
      wb_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= mem_rd_en;
      rd_vec_q[0] <= rd_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_vec_q[i] <= rd_vec_q[i-1];
      end
      wb_vld_q[0] <= ret_vec;
      for (int unsigned i = 1; i < WB_LAT; i++) wb_vld_q[i] <= wb_vld_q[i-1];
      if (start_ok) begin
        wr_cnt  <= '0;
        w_row_q <= '0;
      end else begin
        if (mem_wr_en) wr_cnt  <= wr_cnt + 1'b1;
        if (ret_wgt)   w_row_q <= w_row_q + 1'b1;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign state      = state_q;
  assign pe_w_valid = ret_wgt;
  assign pe_w_row   = ret_wgt ? w_row_q : '0;
  assign pe_weight  = ret_wgt ? mem_rdata : '0;
  assign vec_in     = ret_vec ? mem_rdata : '0;
  assign mem_wr_en  = wb_vld_q[WB_LAT-1];
  assign mem_waddr  = mem_wr_en ? (wbase_q + wr_cnt) : '0;
  assign mem_wdata  = mem_wr_en ? prod_aligned : '0;

  vmx_skew_line #(.LANES(PE_SIZE), .WIDTH(PORT_WIDTH), .REVERSE(1'b0)) u_in_skew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (vec_in),
    .dout (pe_vector)
  );

  vmx_skew_line #(.LANES(PE_SIZE), .WIDTH(PROD_LANE_W), .REVERSE(1'b1)) u_out_deskew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pe_product),
    .dout (prod_aligned)
  );

`ifdef VMX_PERF_EN
  // Busy-cycle counter: cleared by an accepted start, saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       perf_cycles <= '0;
    else if (start_ok)                perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_vmx_stream_sequencer.sv
// Self-checking bench for vmx_stream_sequencer with a synchronous memory
// model and a behavioural systolic-array model (PE_SIZE=4, RD_LAT=1, PE_LAT=4).
module tb_vmx_stream_sequencer;
  localparam int PE_SIZE = 4, PORT_WIDTH = 16, ADDR_W = 8, RD_LAT = 1, PE_LAT = 4;
  localparam int LW = PE_SIZE * PORT_WIDTH;
  localparam int PW = 2 * LW;
  localparam int LAT = RD_LAT + PE_LAT + PE_SIZE - 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] rbase_addr = '0, wbase_addr = '0, num_vec = '0;
  logic busy, done, mem_rd_en, mem_wr_en, pe_clr, pe_w_valid;
  logic [2:0] state;
  logic [7:0] mem_raddr, mem_waddr;
  logic [LW-1:0] mem_rdata = '0, pe_weight, pe_vector;
  logic [PW-1:0] mem_wdata, pe_product = '0;
  logic [1:0] pe_w_row;
`ifdef VMX_PERF_EN
  logic [31:0] perf_cycles;
`endif

  vmx_stream_sequencer #(.PE_SIZE(PE_SIZE), .PORT_WIDTH(PORT_WIDTH), .ADDR_W(ADDR_W),
                         .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rbase_addr(rbase_addr), .wbase_addr(wbase_addr), .num_vec(num_vec),
    .busy(busy), .done(done), .state(state),
    .mem_raddr(mem_raddr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .pe_clr(pe_clr), .pe_w_valid(pe_w_valid), .pe_w_row(pe_w_row),
    .pe_weight(pe_weight), .pe_vector(pe_vector),
`ifdef VMX_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .pe_product(pe_product)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; int cyc; } rd_t;
  typedef struct { logic [7:0] addr; logic [PW-1:0] data; int cyc; } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  int done_q[$], clr_q[$];
  int n_cmp = 0, n_bad = 0, pcyc = 0, busy_cnt = 0, acyc = 0;
  logic [LW-1:0] mem [256];
  logic [LW-1:0] wmat [PE_SIZE];
  logic [LW-1:0] wmod [PE_SIZE];
  logic [LW-1:0] hist [64];
  logic [PW-1:0] exp_q[$];

  always @(posedge clk) pcyc <= pcyc + 1;

  // Synchronous local memory, one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_raddr];

  // Behavioural array: column c of a vector entering lane 0 at t0 appears at t0+PE_LAT+c
  always @(posedge clk) begin
    logic [PW-1:0] p;
    logic [31:0] acc;
    int idx;
    #1;
    acyc++;
    hist[acyc & 63] = pe_vector;
    if (pe_clr) for (int r = 0; r < PE_SIZE; r++) wmod[r] = '0;
    if (pe_w_valid) wmod[pe_w_row] = pe_weight;
    p = '0;
    for (int c = 0; c < PE_SIZE; c++) begin
      acc = '0;
      for (int k = 0; k < PE_SIZE; k++) begin
        idx = acyc - PE_LAT - c + k;
        if (idx >= 0)
          acc = acc + 32'(wmod[k][c*16 +: 16]) * 32'(hist[idx & 63][k*16 +: 16]);
      end
      p[c*32 +: 32] = acc;
    end
    pe_product = p;
  end

  // Event log, sampled mid-cycle and labelled with the preceding edge number
  always @(negedge clk) begin
    if (mem_rd_en) rd_q.push_back('{addr: mem_raddr, cyc: pcyc});
    if (mem_wr_en) wr_q.push_back('{addr: mem_waddr, data: mem_wdata, cyc: pcyc});
    if (done) done_q.push_back(pcyc);
    if (pe_clr) clr_q.push_back(pcyc);
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain job, 1: extra start pulse during STREAM, 2: abort after 2nd write
  task automatic run_job(input logic [7:0] rb, input logic [7:0] wb, input int nv,
                         input bit ident, input int mode);
    logic [LW-1:0] x;
    logic [PW-1:0] e;
    logic [31:0] acc;
    int t0, a, budget, late;
    for (int r = 0; r < PE_SIZE; r++) begin
      wmat[r] = {$urandom, $urandom};
      if (ident) begin
        wmat[r] = '0;
        wmat[r][r*16 +: 16] = 16'd1;
      end
      mem[8'(rb + r)] = wmat[r];
    end
    exp_q.delete();
    for (int v = 0; v < nv; v++) begin
      x = {$urandom, $urandom};
      mem[8'(rb + PE_SIZE + v)] = x;
      for (int c = 0; c < PE_SIZE; c++) begin
        acc = '0;
        for (int r = 0; r < PE_SIZE; r++)
          acc = acc + 32'(wmat[r][c*16 +: 16]) * 32'(x[r*16 +: 16]);
        e[c*32 +: 32] = acc;
      end
      exp_q.push_back(e);
    end
    rd_q.delete(); wr_q.delete(); done_q.delete(); clr_q.delete();
    busy_cnt = 0;
    rbase_addr = rb; wbase_addr = wb; num_vec = 8'(nv); start = 1'b1;
    tick();
    start = 1'b0;
    t0 = pcyc;
    rbase_addr = 8'($urandom); wbase_addr = 8'($urandom); num_vec = 8'($urandom);
    if (mode == 1) begin
      while (pcyc < t0 + 5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (mode == 2) begin
      budget = 0;
      while (wr_q.size() < 2 && budget < 200) begin tick(); budget++; end
      check("abort_wait_2nd_write", 128'(wr_q.size() >= 2), 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      a = pcyc;
      check("abort_state_idle", state, 0);
      check("abort_busy_low", busy, 0);
      repeat (30) tick();
      late = 0;
      foreach (wr_q[i]) if (wr_q[i].cyc >= a) late++;
      check("abort_late_writes", late, 0);
      late = 0;
      foreach (rd_q[i]) if (rd_q[i].cyc >= a) late++;
      check("abort_late_reads", late, 0);
      check("abort_no_done", done_q.size(), 0);
    end else begin
      budget = 0;
      while (done_q.size() == 0 && budget < 300) begin tick(); budget++; end
      repeat (3) tick();
      check("done_count", done_q.size(), 1);
      check("clr_cycle", 128'(clr_q.size() == 1 && clr_q[0] == t0), 1);
      check("rd_count", rd_q.size(), PE_SIZE + nv);
      for (int i = 0; i < rd_q.size() && i < PE_SIZE + nv; i++) begin
        check($sformatf("rd_addr[%0d]", i), rd_q[i].addr, 8'(rb + i));
        check($sformatf("rd_cyc[%0d]", i), rd_q[i].cyc, t0 + 1 + i);
      end
      check("wr_count", wr_q.size(), nv);
      for (int i = 0; i < wr_q.size() && i < nv; i++) begin
        check($sformatf("wr_addr[%0d]", i), wr_q[i].addr, 8'(wb + i));
        check($sformatf("wr_data[%0d]", i), wr_q[i].data, exp_q[i]);
        check($sformatf("wr_cyc[%0d]", i), wr_q[i].cyc, t0 + PE_SIZE + 1 + i + LAT);
      end
      if (nv > 0 && done_q.size() > 0)
        check("done_cycle", done_q[0], t0 + PE_SIZE + LAT + nv + 1);
      else if (done_q.size() > 0)
        check("done_after_weights", 128'(done_q[0] > t0 + PE_SIZE), 1);
      check("end_busy_low", busy, 0);
      check("end_state_idle", state, 0);
`ifdef VMX_PERF_EN
      check("perf_cycles", perf_cycles, busy_cnt);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_waddr", mem_waddr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_pe_clr", pe_clr, 0);
    check("rst_w_valid", pe_w_valid, 0);
    check("rst_w_row", pe_w_row, 0);
    check("rst_weight", pe_weight, 0);
    check("rst_vector", pe_vector, 0);

    run_job(8'h10, 8'h80, 3, 1'b1, 0);   // identity weights, timing reference
    run_job(8'h50, 8'h90, 0, 1'b0, 0);   // empty job
    run_job(8'h20, 8'h40, 8, 1'b0, 2);   // abort mid write-back
    run_job(8'h60, 8'hA0, 5, 1'b0, 1);   // start ignored while streaming
    run_job(8'hFE, 8'hC0, 4, 1'b0, 0);   // read address wrap
    for (int j = 0; j < 3; j++)
      run_job(8'($urandom), 8'($urandom), int'($urandom_range(1, 10)), 1'b0, 0);

    // Asynchronous reset while streaming
    rbase_addr = 8'h30; wbase_addr = 8'hD0; num_vec = 8'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("pre_reset_rd_en", mem_rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd_en", mem_rd_en, 0);
    check("async_rst_wr_en", mem_wr_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_state", state, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
